apu_dispatcher: RTL and testbench
=================================

APU_DISPATCHER -- requirements
Module: apu_dispatcher

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, pending-instruction buffer depth (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, WAIT_RESP cycle limit (used only with REQ-030).
REQ-003 SHALL have ports:
 - clk  in  1  clock; all logic on rising edge.
 - n_reset  in  1  reset, synchronous, active-low.
 - instr_valid  in  1  core offers an instruction.
 - instr_ready  out  1  dispatcher accepts the instruction this cycle.
 - instr_word  in  32  raw instruction.
 - rs1_val, rs2_val  in  32 each  scalar operands.
 - instr_flags  in  15  per-instruction flags.
 - apu_req  out  1  request to vector unit.
 - apu_operands  out  3x32  [0]=instr_word, [1]=rs1_val, [2]=rs2_val.
 - apu_op  out  6  {funct3, 1'b0, major_opcode}.
 - apu_flags_o  out  15  stored instr_flags.
 - apu_gnt  in  1  vector unit grants request.
 - apu_rvalid  in  1  vector unit finished instruction.
 - done  out  1  one-cycle pulse per completed instruction.
 - illegal_instr  out  1  one-cycle pulse per rejected instruction.
 - busy  out  1  high when state != IDLE or FIFO non-empty.
 - timeout_err  out  1  one-cycle pulse (REQ-030).

Function
REQ-004 SHALL accept when instr_valid && instr_ready; instr_ready = !fifo_full (no pass-through when full, even if popping).
REQ-005 SHALL map instr_word[6:0]: 0000111->LOAD_FP, 0100111->STORE_FP, 1010111->OP_V; funct3 = instr_word[14:12].
REQ-006 SHALL, for any other opcode, accept but not enqueue, and pulse illegal_instr the cycle after acceptance.
REQ-007 SHALL enqueue {instr_word, rs1_val, rs2_val, instr_flags, apu_op} for legal instructions; strict FIFO order.
REQ-008 SHALL implement FSM IDLE, REQ, WAIT_RESP.
REQ-009 IDLE: fifo non-empty -> REQ next cycle; else stay.
REQ-010 REQ: apu_req=1; apu_operands/apu_op/apu_flags_o driven from FIFO head, stable until grant; on apu_gnt pop head -> WAIT_RESP.
REQ-011 WAIT_RESP: apu_req=0; on apu_rvalid pulse done -> IDLE.
REQ-012 apu_rvalid outside WAIT_RESP SHALL be ignored; apu_gnt outside REQ SHALL be ignored.
REQ-013 Latency: accept at cycle 0 into empty FIFO in IDLE -> apu_req high in cycle 2; rvalid at cycle N -> done high in cycle N+1.
REQ-014 At most one instruction outstanding at the vector unit at any time.
REQ-015 Simultaneous push and pop (not full) SHALL leave count unchanged and preserve order.
REQ-016 apu_operands/apu_op/apu_flags_o SHALL be 0 when apu_req=0.

Reset
REQ-020 With n_reset low at a clock edge: state=IDLE, FIFO empty, apu_req=0, done=0, illegal_instr=0, timeout_err=0, instr_ready=0 during reset, busy=0.
REQ-021 Reset mid-operation SHALL abandon any outstanding request/response without waiting; pending entries discarded.
REQ-022 instr_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-030 With APU_DISPATCH_TIMEOUT_EN defined: cycle counter cleared on WAIT_RESP entry; when it reaches TIMEOUT_CYCLES without apu_rvalid, pulse timeout_err and go IDLE (no done); apu_rvalid in the same cycle wins (done, no timeout_err).
REQ-031 Without APU_DISPATCH_TIMEOUT_EN: no counter, WAIT_RESP waits indefinitely, timeout_err tied 0.

Structure
REQ-040 Major opcode constants (LOAD_FP, STORE_FP, OP_V), funct3 constants, FSM state typedef and FIFO entry struct SHALL live in accelerator_pkg.
REQ-041 FIFO SHALL be sub-module apu_instr_fifo (parameterised depth/width, full/empty/count).

Verification
REQ-050 Single vadd.vv (0x02208057), gnt immediate, rvalid 3 cycles later -> apu_req cycles 2, apu_op={000,0,OP_V}, done one cycle after rvalid.
REQ-051 Three back-to-back legal instructions, FIFO_DEPTH=2, gnt held low -> instr_ready low after 2 enqueued; issue order matches accept order.
REQ-052 instr_word opcode 0110011 -> illegal_instr pulse next cycle, apu_req never asserted, busy stays 0.
REQ-053 apu_gnt low 5 cycles in REQ -> apu_req and operands held stable all 5 cycles; spurious rvalid in REQ ignored.
REQ-054 Reset asserted in WAIT_RESP with 1 queued entry -> next cycle IDLE, FIFO empty, no done on later rvalid.
REQ-055 TIMEOUT_EN, TIMEOUT_CYCLES=4, no rvalid -> timeout_err pulse exactly once, state IDLE; rvalid on limit cycle -> done only.

Source files
------------

// File: rtl/accelerator_pkg.sv
// rtl/accelerator_pkg.sv - shared opcode constants, FSM state and FIFO entry types for the APU dispatcher
package accelerator_pkg;

    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_OP_V     = 7'b1010111;

    localparam logic [2:0] F3_OPIVV = 3'b000;
    localparam logic [2:0] F3_OPFVV = 3'b001;
    localparam logic [2:0] F3_OPMVV = 3'b010;
    localparam logic [2:0] F3_OPIVI = 3'b011;
    localparam logic [2:0] F3_OPIVX = 3'b100;
    localparam logic [2:0] F3_OPFVF = 3'b101;
    localparam logic [2:0] F3_OPMVX = 3'b110;
    localparam logic [2:0] F3_OPCFG = 3'b111;

    // Compact major-opcode code carried in the low bits of apu_op
    typedef enum logic [1:0] {
        MAJ_LOAD_FP  = 2'd0,
        MAJ_STORE_FP = 2'd1,
        MAJ_OP_V     = 2'd2
    } major_op_e;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_RESP = 2'd2
    } disp_state_e;

    typedef struct packed {
        logic [31:0] instr_word;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [14:0] flags;
        logic [5:0]  op;
    } fifo_entry_t;

    // Returns {legal, apu_op}; apu_op = {funct3, 1'b0, major}
    function automatic logic [6:0] decode_op(input logic [31:0] word);
        logic      legal;
        major_op_e maj;
        legal = 1'b1;
        maj   = MAJ_LOAD_FP;
        case (word[6:0])
            OPC_LOAD_FP:  maj = MAJ_LOAD_FP;
            OPC_STORE_FP: maj = MAJ_STORE_FP;
            OPC_OP_V:     maj = MAJ_OP_V;
            default:      legal = 1'b0;
        endcase
        return {legal, word[14:12], 1'b0, maj};
    endfunction

endpackage

// File: rtl/apu_instr_fifo.sv
// rtl/apu_instr_fifo.sv - synchronous FIFO holding pending instructions (power-of-two depth)
module apu_instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/apu_dispatcher.sv
// rtl/apu_dispatcher.sv - queues vector/FP instructions and issues them one at a time to the APU
// Optional WAIT_RESP watchdog enabled by APU_DISPATCH_TIMEOUT_EN.
module apu_dispatcher
    import accelerator_pkg::*;
#(
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr_word,
    input  logic [31:0]       rs1_val,
    input  logic [31:0]       rs2_val,
    input  logic [14:0]       instr_flags,
    output logic              apu_req,
    output logic [2:0][31:0]  apu_operands,
    output logic [5:0]        apu_op,
    output logic [14:0]       apu_flags_o,
    input  logic              apu_gnt,
    input  logic              apu_rvalid,
    output logic              done,
    output logic              illegal_instr,
    output logic              busy,
    output logic              timeout_err
);

    localparam int EW = $bits(fifo_entry_t);

    disp_state_e                 state;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [EW-1:0]               fifo_rdata;
    fifo_entry_t                 head;
    fifo_entry_t                 new_entry;
    logic [6:0]                  dec;
    logic                        accept;
    logic                        push;
    logic                        pop;

    assign instr_ready = n_reset && !fifo_full;
    assign accept      = instr_valid && instr_ready;
    assign dec         = decode_op(instr_word);
    assign push        = accept && dec[6];
    assign pop         = (state == S_REQ) && apu_gnt;

    assign new_entry.instr_word = instr_word;
    assign new_entry.rs1_val    = rs1_val;
    assign new_entry.rs2_val    = rs2_val;
    assign new_entry.flags      = instr_flags;
    assign new_entry.op         = dec[5:0];

    apu_instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push),
        .wdata   (new_entry),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head    = fifo_entry_t'(fifo_rdata);
    assign apu_req = (state == S_REQ);
    assign busy    = (state != S_IDLE) || (fifo_count != '0);

    // Head is only popped on grant, so these stay stable for the whole request
    assign apu_operands[0] = apu_req ? head.instr_word : 32'd0;
    assign apu_operands[1] = apu_req ? head.rs1_val    : 32'd0;
    assign apu_operands[2] = apu_req ? head.rs2_val    : 32'd0;
    assign apu_op          = apu_req ? head.op         : 6'd0;
    assign apu_flags_o     = apu_req ? head.flags      : 15'd0;

`ifdef APU_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_q;
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state         <= S_IDLE;
            done          <= 1'b0;
            illegal_instr <= 1'b0;
`ifdef APU_DISPATCH_TIMEOUT_EN
            tmo_cnt       <= '0;
            tmo_q         <= 1'b0;
`endif
        end else begin
            done          <= 1'b0;
            illegal_instr <= accept && !dec[6];
`ifdef APU_DISPATCH_TIMEOUT_EN
            tmo_q         <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) state <= S_REQ;
                end
                S_REQ: begin
                    if (apu_gnt) begin
                        state <= S_WAIT_RESP;
`ifdef APU_DISPATCH_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                S_WAIT_RESP: begin
                    // A response arriving on the limit cycle takes priority over the timeout
                    if (apu_rvalid) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
`ifdef APU_DISPATCH_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        tmo_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apu_dispatcher.sv
// tb/tb_apu_dispatcher.sv - directed table-driven bench for apu_dispatcher
module tb_apu_dispatcher;

    logic             clk = 1'b0;
    logic             n_reset = 1'b0;
    logic             instr_valid = 1'b0;
    logic             instr_ready;
    logic [31:0]      instr_word = '0;
    logic [31:0]      rs1_val = '0;
    logic [31:0]      rs2_val = '0;
    logic [14:0]      instr_flags = '0;
    logic             apu_req;
    logic [2:0][31:0] apu_operands;
    logic [5:0]       apu_op;
    logic [14:0]      apu_flags_o;
    logic             apu_gnt = 1'b0;
    logic             apu_rvalid = 1'b0;
    logic             done;
    logic             illegal_instr;
    logic             busy;
    logic             timeout_err;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    apu_dispatcher #(
        .FIFO_DEPTH     (2),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_word    (instr_word),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .instr_flags   (instr_flags),
        .apu_req       (apu_req),
        .apu_operands  (apu_operands),
        .apu_op        (apu_op),
        .apu_flags_o   (apu_flags_o),
        .apu_gnt       (apu_gnt),
        .apu_rvalid    (apu_rvalid),
        .done          (done),
        .illegal_instr (illegal_instr),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [14:0] flags;
        logic        illegal;
        logic [5:0]  op;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                         input logic [14:0] f);
        instr_valid = 1'b1;
        instr_word  = w;
        rs1_val     = a;
        rs2_val     = b;
        instr_flags = f;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic serve(input string name, input logic [31:0] exp_word);
        int n;
        n = 0;
        while (!apu_req && n < 16) begin
            step();
            n++;
        end
        check({name, "_req"}, apu_req, 1);
        check({name, "_word"}, apu_operands[0], exp_word);
        apu_gnt = 1'b1;
        step();
        apu_gnt = 1'b0;
        apu_rvalid = 1'b1;
        step();
        apu_rvalid = 1'b0;
        check({name, "_done"}, done, 1);
    endtask

    initial begin
        vecs[0] = '{32'h0220_8057, 32'h1111_1111, 32'h2222_2222, 15'h1234, 1'b0, 6'h02};
        vecs[1] = '{32'h0000_2007, 32'hAAAA_0001, 32'h0000_0000, 15'h7FFF, 1'b0, 6'h10};
        vecs[2] = '{32'h0000_7027, 32'h0000_0040, 32'hDEAD_BEEF, 15'h0001, 1'b0, 6'h39};
        vecs[3] = '{32'h0000_3057, 32'h1234_5678, 32'h8765_4321, 15'h4000, 1'b0, 6'h1A};
        vecs[4] = '{32'h0000_0033, 32'h0000_0001, 32'h0000_0002, 15'h0003, 1'b1, 6'h00};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0006, 15'h0007, 1'b1, 6'h00};

        // Reset state
        step();
        step();
        check("rst_req", apu_req, 0);
        check("rst_done", done, 0);
        check("rst_illegal", illegal_instr, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_ready", instr_ready, 0);
        check("rst_busy", busy, 0);
        n_reset = 1'b1;
        #1;
        check("rel_ready", instr_ready, 1);

        for (int i = 0; i < 6; i++) begin
            offer(vecs[i].word, vecs[i].rs1, vecs[i].rs2, vecs[i].flags);
            if (vecs[i].illegal) begin
                check($sformatf("v%0d_illegal_c1", i), illegal_instr, 1);
                check($sformatf("v%0d_busy_c1", i), busy, 0);
                check($sformatf("v%0d_req_c1", i), apu_req, 0);
                step();
                check($sformatf("v%0d_illegal_c2", i), illegal_instr, 0);
                check($sformatf("v%0d_req_c2", i), apu_req, 0);
                check($sformatf("v%0d_busy_c2", i), busy, 0);
            end else begin
                check($sformatf("v%0d_req_c1", i), apu_req, 0);
                check($sformatf("v%0d_illegal", i), illegal_instr, 0);
                step();
                check($sformatf("v%0d_req_c2", i), apu_req, 1);
                check($sformatf("v%0d_op", i), apu_op, vecs[i].op);
                check($sformatf("v%0d_opnd0", i), apu_operands[0], vecs[i].word);
                check($sformatf("v%0d_opnd1", i), apu_operands[1], vecs[i].rs1);
                check($sformatf("v%0d_opnd2", i), apu_operands[2], vecs[i].rs2);
                check($sformatf("v%0d_flags", i), apu_flags_o, vecs[i].flags);
                apu_gnt = 1'b1;
                step();
                apu_gnt = 1'b0;
                check($sformatf("v%0d_req_wait", i), apu_req, 0);
                check($sformatf("v%0d_opnd_zero", i), {32'd0, apu_operands[0] | apu_operands[1] | apu_operands[2]}, 0);
                check($sformatf("v%0d_op_zero", i), apu_op, 0);
                step();
                step();
                apu_rvalid = 1'b1;
                step();
                apu_rvalid = 1'b0;
                check($sformatf("v%0d_done", i), done, 1);
                step();
                check($sformatf("v%0d_done_clr", i), done, 0);
                check($sformatf("v%0d_busy_end", i), busy, 0);
            end
        end

        // Three back-to-back instructions with grant held off
        instr_valid = 1'b1;
        instr_word = 32'h0000_0057; rs1_val = 32'hA; rs2_val = 32'hA; instr_flags = 15'h0A;
        step();
        instr_word = 32'h0000_1057; rs1_val = 32'hB; rs2_val = 32'hB; instr_flags = 15'h0B;
        step();
        instr_word = 32'h0000_2057; rs1_val = 32'hC; rs2_val = 32'hC; instr_flags = 15'h0C;
        check("b2b_ready_full", instr_ready, 0);
        check("b2b_head_a", apu_operands[0], 32'h0000_0057);
        step();
        step();
        check("b2b_ready_held", instr_ready, 0);
        apu_gnt = 1'b1;
        step();
        apu_gnt = 1'b0;
        check("b2b_ready_after_pop", instr_ready, 1);
        step();
        instr_valid = 1'b0;
        apu_rvalid = 1'b1;
        step();
        apu_rvalid = 1'b0;
        check("b2b_done_a", done, 1);
        serve("b2b_b", 32'h0000_1057);
        serve("b2b_c", 32'h0000_2057);
        step();
        check("b2b_idle", busy, 0);

        // Grant withheld for 5 cycles with spurious rvalid during REQ
        offer(32'h0000_4057, 32'h5555_AAAA, 32'h0F0F_0F0F, 15'h2AAA);
        step();
        apu_rvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d_req", k), apu_req, 1);
            check($sformatf("hold%0d_rs1", k), apu_operands[1], 32'h5555_AAAA);
            check($sformatf("hold%0d_op", k), apu_op, 6'h22);
            check($sformatf("hold%0d_done", k), done, 0);
            step();
        end
        apu_rvalid = 1'b0;
        serve("hold_end", 32'h0000_4057);

        // Reset while waiting for response with one entry queued
        offer(32'h0000_0057, 32'h1, 32'h2, 15'h1);
        offer(32'h0000_1057, 32'h3, 32'h4, 15'h2);
        check("rstw_req", apu_req, 1);
        apu_gnt = 1'b1;
        step();
        apu_gnt = 1'b0;
        check("rstw_busy_before", busy, 1);
        n_reset = 1'b0;
        step();
        check("rstw_busy", busy, 0);
        check("rstw_req_low", apu_req, 0);
        check("rstw_ready_low", instr_ready, 0);
        n_reset = 1'b1;
        #1;
        check("rstw_ready_rel", instr_ready, 1);
        apu_rvalid = 1'b1;
        step();
        apu_rvalid = 1'b0;
        check("rstw_no_done", done, 0);
        step();
        check("rstw_no_req", apu_req, 0);
        check("rstw_idle", busy, 0);

`ifdef APU_DISPATCH_TIMEOUT_EN
        offer(32'h0000_0057, 32'h1, 32'h2, 15'h1);
        step();
        apu_gnt = 1'b1;
        step();
        apu_gnt = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("tmo_c%0d", k), timeout_err, (k == 4) ? 64'd1 : 64'd0);
        end
        check("tmo_no_done", done, 0);
        check("tmo_idle", busy, 0);
        step();
        check("tmo_once", timeout_err, 0);
        offer(32'h0000_0057, 32'h1, 32'h2, 15'h1);
        step();
        apu_gnt = 1'b1;
        step();
        apu_gnt = 1'b0;
        step();
        step();
        step();
        apu_rvalid = 1'b1;
        step();
        apu_rvalid = 1'b0;
        check("tmo_race_done", done, 1);
        check("tmo_race_err", timeout_err, 0);
`else
        offer(32'h0000_0057, 32'h1, 32'h2, 15'h1);
        step();
        apu_gnt = 1'b1;
        step();
        apu_gnt = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check("notmo_err", timeout_err, 0);
        check("notmo_waiting", busy, 1);
        apu_rvalid = 1'b1;
        step();
        apu_rvalid = 1'b0;
        check("notmo_done", done, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
